// File: rtl/pipe_scoreboard_if.sv
// IDU->EXU issue handshake bundle: decoded operand/destination fields plus valid/ready.
interface pipe_scoreboard_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_use_rs1;
    logic       issue_use_rs2;
    logic [4:0] issue_rd;
    logic       issue_rd_wen;
    logic       issue_is_load;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_rd_wen, issue_is_load,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_rd_wen, issue_is_load,
        output issue_ready
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Counted-writer register scoreboard gating IDU->EXU issue; tracks pending writers and
// outstanding loads per architectural register (x0 untracked).
module pipe_scoreboard #(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    pipe_scoreboard_if.slave     issue,
    input  logic                 ld_done_valid,
    input  logic [4:0]           ld_done_rd,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic                 sb_clear,
    output logic [NREG-1:0]      busy_mask,
    output logic [31:0]          stall_cycles,
    output logic                 sb_err
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    cnt_t pend_cnt [NREG];
    cnt_t load_cnt [NREG];
    cnt_t pend_nxt [NREG];
    cnt_t load_nxt [NREG];

    logic            haz1, haz2, hold, issue_wr, err_nxt;
    logic [NREG-1:0] inc_vec, ldinc_vec, wb_vec, lddec_vec;

    always_comb begin
        haz1 = issue.issue_use_rs1 && (issue.issue_rs1 != '0) &&
               (FWD_EN ? (load_cnt[issue.issue_rs1] != '0) : (pend_cnt[issue.issue_rs1] != '0));
        haz2 = issue.issue_use_rs2 && (issue.issue_rs2 != '0) &&
               (FWD_EN ? (load_cnt[issue.issue_rs2] != '0) : (pend_cnt[issue.issue_rs2] != '0));
        hold = issue.issue_rd_wen && (issue.issue_rd != '0) && (pend_cnt[issue.issue_rd] == '1);
    end

    // Ready looks only at the registered table; same-cycle retires take effect next cycle.
    assign issue.issue_ready = !(haz1 || haz2 || hold);

    always_comb begin
        issue_wr  = issue.issue_valid && issue.issue_ready && issue.issue_rd_wen && (issue.issue_rd != '0);
        inc_vec   = issue_wr ? (ONE << issue.issue_rd) : '0;
        ldinc_vec = (issue_wr && issue.issue_is_load) ? (ONE << issue.issue_rd) : '0;
        wb_vec    = (wb_valid && (wb_rd != '0)) ? (ONE << wb_rd) : '0;
        lddec_vec = (ld_done_valid && (ld_done_rd != '0)) ? (ONE << ld_done_rd) : '0;
    end

    // Per-register net update: +1 and -1 together cancel; decrement at zero flags an error.
    always_comb begin
        err_nxt     = 1'b0;
        pend_nxt[0] = '0;
        load_nxt[0] = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            pend_nxt[i] = pend_cnt[i];
            load_nxt[i] = load_cnt[i];
            if (inc_vec[i] && !wb_vec[i]) begin
                if (pend_cnt[i] != '1) pend_nxt[i] = pend_cnt[i] + 1'b1;
            end else if (wb_vec[i] && !inc_vec[i]) begin
                if (pend_cnt[i] == '0) err_nxt = 1'b1;
                else                   pend_nxt[i] = pend_cnt[i] - 1'b1;
            end
            if (ldinc_vec[i] && !lddec_vec[i]) begin
                if (load_cnt[i] != '1) load_nxt[i] = load_cnt[i] + 1'b1;
            end else if (lddec_vec[i] && !ldinc_vec[i]) begin
                if (load_cnt[i] == '0) err_nxt = 1'b1;
                else                   load_nxt[i] = load_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                pend_cnt[i] <= '0;
                load_cnt[i] <= '0;
            end
            stall_cycles <= '0;
            sb_err       <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                pend_cnt[i] <= sb_clear ? '0 : pend_nxt[i];
                load_cnt[i] <= sb_clear ? '0 : load_nxt[i];
            end
            if (issue.issue_valid && !issue.issue_ready) stall_cycles <= stall_cycles + 32'd1;
            if (err_nxt && !sb_clear) sb_err <= 1'b1;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < NREG; i++) busy_mask[i] = (pend_cnt[i] != '0);
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: one forwarding instance and one non-forwarding instance.
module tb_pipe_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    int          checks = 0;
    int          failures = 0;

    logic        f_ld_v, f_wb_v, f_clr, f_err;
    logic [4:0]  f_ld_rd, f_wb_rd;
    logic [31:0] f_busy, f_stall;
    logic        n_ld_v, n_wb_v, n_clr, n_err;
    logic [4:0]  n_ld_rd, n_wb_rd;
    logic [31:0] n_busy, n_stall;

    pipe_scoreboard_if fi ();
    pipe_scoreboard_if ni ();

    pipe_scoreboard #(.NREG(32), .CNT_W(2), .FWD_EN(1'b1)) u_fwd (
        .clock(clock), .reset(reset), .issue(fi.slave),
        .ld_done_valid(f_ld_v), .ld_done_rd(f_ld_rd), .wb_valid(f_wb_v), .wb_rd(f_wb_rd),
        .sb_clear(f_clr), .busy_mask(f_busy), .stall_cycles(f_stall), .sb_err(f_err)
    );

    pipe_scoreboard #(.NREG(32), .CNT_W(2), .FWD_EN(1'b0)) u_nofwd (
        .clock(clock), .reset(reset), .issue(ni.slave),
        .ld_done_valid(n_ld_v), .ld_done_rd(n_ld_rd), .wb_valid(n_wb_v), .wb_rd(n_wb_rd),
        .sb_clear(n_clr), .busy_mask(n_busy), .stall_cycles(n_stall), .sb_err(n_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic f_idle();
        fi.issue_valid = 0; fi.issue_rs1 = 0; fi.issue_rs2 = 0; fi.issue_use_rs1 = 0;
        fi.issue_use_rs2 = 0; fi.issue_rd = 0; fi.issue_rd_wen = 0; fi.issue_is_load = 0;
        f_ld_v = 0; f_ld_rd = 0; f_wb_v = 0; f_wb_rd = 0; f_clr = 0;
    endtask

    task automatic n_idle();
        ni.issue_valid = 0; ni.issue_rs1 = 0; ni.issue_rs2 = 0; ni.issue_use_rs1 = 0;
        ni.issue_use_rs2 = 0; ni.issue_rd = 0; ni.issue_rd_wen = 0; ni.issue_is_load = 0;
        n_ld_v = 0; n_ld_rd = 0; n_wb_v = 0; n_wb_rd = 0; n_clr = 0;
    endtask

    task automatic f_set(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wen, input logic ld);
        fi.issue_valid = 1; fi.issue_rs1 = rs1; fi.issue_use_rs1 = u1; fi.issue_rs2 = rs2;
        fi.issue_use_rs2 = u2; fi.issue_rd = rd; fi.issue_rd_wen = wen; fi.issue_is_load = ld;
    endtask

    task automatic n_set(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic wen);
        ni.issue_valid = 1; ni.issue_rs1 = rs1; ni.issue_use_rs1 = u1; ni.issue_rs2 = 0;
        ni.issue_use_rs2 = 0; ni.issue_rd = rd; ni.issue_rd_wen = wen; ni.issue_is_load = 0;
    endtask

    initial begin
        reset = 1'b1;
        f_idle();
        n_idle();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", f_busy, 32'h0);
        chk("rst_stall", f_stall, 32'd0);
        chk("rst_err", {31'd0, f_err}, 32'd0);
        chk("rst_ready", {31'd0, fi.issue_ready}, 32'd1);

        // addi x5, then writeback x5
        f_set(0, 0, 0, 0, 5, 1, 0);
        #1 chk("t1_ready", {31'd0, fi.issue_ready}, 32'd1);
        step(); f_idle();
        chk("t1_busy", f_busy, 32'h20);
        f_wb_v = 1; f_wb_rd = 5;
        step(); f_idle();
        chk("t1_busy_clr", f_busy, 32'h0);
        chk("t1_err", {31'd0, f_err}, 32'd0);

        // lw x6; add x7,x6,x1 held until ld_done x6
        f_set(0, 0, 0, 0, 6, 1, 1);
        step(); f_idle();
        chk("t2_busy_ld", f_busy, 32'h40);
        f_set(6, 1, 1, 1, 7, 1, 0);
        #1 chk("t2_hold", {31'd0, fi.issue_ready}, 32'd0);
        step(); step();
        f_ld_v = 1; f_ld_rd = 6;
        #1 chk("t2_nobypass", {31'd0, fi.issue_ready}, 32'd0);
        step();
        f_ld_v = 0;
        #1 chk("t2_release", {31'd0, fi.issue_ready}, 32'd1);
        chk("t2_stall", f_stall, 32'd3);
        step(); f_idle();
        chk("t2_busy", f_busy, 32'hC0);
        f_wb_v = 1; f_wb_rd = 6; step();
        f_wb_rd = 7; step(); f_idle();
        chk("t2_drain", f_busy, 32'h0);

        // forwarding: ALU result consumer never stalls
        f_set(0, 0, 0, 0, 3, 1, 0);
        step();
        f_set(3, 1, 0, 0, 0, 0, 0);
        #1 chk("t3f_ready", {31'd0, fi.issue_ready}, 32'd1);
        step(); f_idle();
        f_wb_v = 1; f_wb_rd = 3; step(); f_idle();
        chk("t3f_stall", f_stall, 32'd3);

        // no forwarding: consumer held until writeback
        n_set(0, 0, 3, 1);
        step();
        n_set(3, 1, 0, 0);
        #1 chk("t3n_hold", {31'd0, ni.issue_ready}, 32'd0);
        step(); step();
        n_wb_v = 1; n_wb_rd = 3;
        #1 chk("t3n_nobypass", {31'd0, ni.issue_ready}, 32'd0);
        step();
        n_wb_v = 0;
        #1 chk("t3n_release", {31'd0, ni.issue_ready}, 32'd1);
        step(); n_idle();
        chk("t3n_stall", n_stall, 32'd3);
        chk("t3n_busy", n_busy, 32'h0);

        // three writers to x9 fill the counter; fourth is a structural hold
        f_set(0, 0, 0, 0, 9, 1, 0);
        step(); step(); step();
        chk("t4_busy", f_busy, 32'h200);
        chk("t4_full", {31'd0, fi.issue_ready}, 32'd0);
        step();
        f_wb_v = 1; f_wb_rd = 9;
        #1 chk("t4_full_wb", {31'd0, fi.issue_ready}, 32'd0);
        step();
        f_wb_v = 0;
        #1 chk("t4_room", {31'd0, fi.issue_ready}, 32'd1);
        f_wb_v = 1; f_wb_rd = 9;
        step();
        f_wb_v = 0;
        #1 chk("t4_net_zero", {31'd0, fi.issue_ready}, 32'd1);
        step();
        chk("t4_full_again", {31'd0, fi.issue_ready}, 32'd0);
        f_idle();
        chk("t4_stall", f_stall, 32'd5);
        f_wb_v = 1; f_wb_rd = 9;
        step(); step(); step(); f_idle();
        chk("t4_drain", f_busy, 32'h0);
        chk("t4_err", {31'd0, f_err}, 32'd0);

        // retire on empty counter; x0 never tracked
        f_wb_v = 1; f_wb_rd = 4;
        step(); f_idle();
        chk("t5_err", {31'd0, f_err}, 32'd1);
        chk("t5_busy", f_busy, 32'h0);
        step();
        chk("t5_sticky", {31'd0, f_err}, 32'd1);
        f_set(0, 1, 0, 1, 0, 1, 1);
        #1 chk("t5_x0_ready", {31'd0, fi.issue_ready}, 32'd1);
        step(); f_idle();
        chk("t5_x0_busy", f_busy, 32'h0);
        chk("t5_x0_stall", f_stall, 32'd5);

        // sb_clear overrides same-cycle issue/retire
        f_set(0, 0, 0, 0, 2, 1, 0); step();
        f_set(0, 0, 0, 0, 8, 1, 0); step(); f_idle();
        chk("t6_busy", f_busy, 32'h104);
        f_set(0, 0, 0, 0, 10, 1, 0);
        f_clr = 1; f_wb_v = 1; f_wb_rd = 2;
        step(); f_idle();
        chk("t6_clear", f_busy, 32'h0);
        chk("t6_stall_kept", f_stall, 32'd5);
        chk("t6_err_kept", {31'd0, f_err}, 32'd1);

        // asynchronous reset during a stall
        f_set(0, 0, 0, 0, 6, 1, 1); step();
        f_set(6, 1, 0, 0, 7, 1, 0);
        #1 chk("t6_hold", {31'd0, fi.issue_ready}, 32'd0);
        step();
        chk("t6_stall", f_stall, 32'd6);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_ready", {31'd0, fi.issue_ready}, 32'd1);
        chk("t6_rst_stall", f_stall, 32'd0);
        chk("t6_rst_busy", f_busy, 32'h0);
        chk("t6_rst_err", {31'd0, f_err}, 32'd0);
        f_idle();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
